// File: rtl/axi_rd_slv_if.sv
// AR/R channel bundle for the single-beat read responder.
// The master modport is the request issuer; the slave modport is the responder.
interface axi_rd_slv_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_slv.sv
// Single-beat AXI read responder: in-order request FIFO feeding an
// IDLE/WAIT/RESP sequencer that returns address-derived data after RD_LAT cycles.
module axi_rd_slv #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 2,
    parameter logic [ADDR_W-1:0] OK_LIMIT = 'h00FF
) (
    input  logic        clk,
    input  logic        rst_n,
    axi_rd_slv_if.slave axi_slv
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ID_W + ADDR_W;
    localparam logic [3:0]     LAT  = 4'(RD_LAT);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              rvalid_reg;
    logic [ID_W-1:0]   rid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [1:0]        rresp_reg;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              r_hs;
    logic [ENT_W-1:0]  head;
    logic [ID_W-1:0]   head_id;
    logic [ADDR_W-1:0] head_addr;
    logic              head_ok;

    assign full  = (count_reg == FULL);
    assign empty = (count_reg == '0);
    assign push  = axi_slv.arvalid & ~full;
    assign r_hs  = rvalid_reg & axi_slv.rready;
    // The head leaves the FIFO either from IDLE or on the edge that retires the current beat.
    assign pop   = ~empty & ((state_reg == IDLE) | ((state_reg == RESP) & r_hs));

    assign head      = mem[rd_ptr_reg];
    assign head_id   = head[ENT_W-1:ADDR_W];
    assign head_addr = head[ADDR_W-1:0];
    assign head_ok   = (head_addr <= OK_LIMIT);

    assign axi_slv.arready = ~full;
    assign axi_slv.rvalid  = rvalid_reg;
    assign axi_slv.rlast   = rvalid_reg;
    assign axi_slv.rid     = rid_reg;
    assign axi_slv.rdata   = rdata_reg;
    assign axi_slv.rresp   = rresp_reg;

    // Storage carries no reset; only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {axi_slv.arid, axi_slv.araddr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rvalid_reg <= 1'b0;
            rid_reg    <= '0;
            rdata_reg  <= '0;
            rresp_reg  <= 2'b00;
        end else begin
            // R fields only load on a pop, which never happens while a beat is stalled.
            if (pop) begin
                rid_reg   <= head_id;
                rdata_reg <= head_ok ? {~head_addr, head_addr} : '0;
                rresp_reg <= head_ok ? 2'b00 : 2'b11;
            end
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        if (LAT == 4'd0) begin
                            state_reg  <= RESP;
                            rvalid_reg <= 1'b1;
                        end else begin
                            cnt_reg   <= LAT;
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd1) begin
                        state_reg  <= RESP;
                        rvalid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (r_hs) begin
                        if (pop) begin
                            if (LAT == 4'd0) begin
                                state_reg  <= RESP;
                                rvalid_reg <= 1'b1;
                            end else begin
                                cnt_reg    <= LAT;
                                state_reg  <= WAIT;
                                rvalid_reg <= 1'b0;
                            end
                        end else begin
                            state_reg  <= IDLE;
                            rvalid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    rvalid_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_slv.sv
// Randomized self-checking bench for axi_rd_slv: an RD_LAT=2 instance and an
// RD_LAT=0 instance checked against a queue-based model of the read target.
module tb_axi_rd_slv;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam logic [15:0] OK_LIMIT = 16'h00FF;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] addr;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_rd_slv_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    axi_rd_slv_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

    axi_rd_slv #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4),
                 .RD_LAT(2), .OK_LIMIT(OK_LIMIT))
        dut (.clk(clk), .rst_n(rst_n), .axi_slv(bus));

    axi_rd_slv #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4),
                 .RD_LAT(0), .OK_LIMIT(OK_LIMIT))
        dut0 (.clk(clk), .rst_n(rst_n), .axi_slv(bus0));

    int n_checks = 0;
    int n_pass   = 0;
    req_t exp_q[$];

    // Expected {rid, rdata, rresp, rlast} for one request.
    function automatic logic [38:0] model_resp(req_t r);
        if (r.addr <= OK_LIMIT) return {r.id, ~r.addr, r.addr, 2'b00, 1'b1};
        return {r.id, 32'h0, 2'b11, 1'b1};
    endfunction

    function automatic req_t rand_req(logic [3:0] id);
        req_t r;
        r.id = id;
        r.addr = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255))
                                             : 16'($urandom_range(256, 65535));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++; if (bus.arready !== 1'b1) $display("FAIL reset_arready got=%b exp=1", bus.arready); else n_pass++;
        n_checks++; if (bus.rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); else n_pass++;
        n_checks++; if (bus.rlast !== 1'b0) $display("FAIL reset_rlast got=%b exp=0", bus.rlast); else n_pass++;
        n_checks++; if ({bus.rid, bus.rdata, bus.rresp} !== 38'h0)
            $display("FAIL reset_rfields got=%h/%h/%b exp=0/0/00", bus.rid, bus.rdata, bus.rresp); else n_pass++;
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++; if ({bus.arready, bus.rvalid, bus0.arready, bus0.rvalid} !== 4'b1010)
            $display("FAIL post_reset_idle got=%b exp=1010", {bus.arready, bus.rvalid, bus0.arready, bus0.rvalid}); else n_pass++;
    endtask

    task automatic single_timing(input req_t r, input string tag);
        logic [3:0]  rv_hist;
        logic [38:0] got;
        got = '0;
        bus.arid = r.id; bus.araddr = r.addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        n_checks++; if (bus.arready !== 1'b1) $display("FAIL %s_arready got=%b exp=1", tag, bus.arready); else n_pass++;
        tick();
        bus.arvalid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            rv_hist[k-1] = bus.rvalid;
            if (k == 3) got = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
        end
        n_checks++; if (rv_hist !== 4'b0100) $display("FAIL %s_latency rvalid_hist got=%b exp=0100", tag, rv_hist); else n_pass++;
        n_checks++; if (got !== model_resp(r)) $display("FAIL %s_fields got=%h exp=%h", tag, got, model_resp(r)); else n_pass++;
    endtask

    task automatic test_single();
        req_t r;
        r.id = 4'h3; r.addr = 16'h0001;
        single_timing(r, "single");
        n_checks++; if (model_resp(r) !== {4'h3, 32'hFFFE0001, 2'b00, 1'b1})
            $display("FAIL single_model got=%h exp=%h", model_resp(r), {4'h3, 32'hFFFE0001, 2'b00, 1'b1}); else n_pass++;
    endtask

    task automatic test_decode();
        req_t tbl [3];
        tbl[0].id = 4'hA; tbl[0].addr = 16'h0100;
        tbl[1].id = 4'h5; tbl[1].addr = 16'h00FF;
        tbl[2].id = 4'hC; tbl[2].addr = 16'hFFFF;
        foreach (tbl[i]) begin
            logic [38:0] got;
            int t;
            bus.arid = tbl[i].id; bus.araddr = tbl[i].addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
            t = 0;
            while (!bus.arready && t < 20) begin tick(); t++; end
            tick();
            bus.arvalid = 1'b0;
            t = 0;
            while (!bus.rvalid && t < 20) begin tick(); t++; end
            got = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
            n_checks++; if (got !== model_resp(tbl[i]))
                $display("FAIL decode_%0d got=%h exp=%h", i, got, model_resp(tbl[i])); else n_pass++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        req_t reqs [6];
        int idx, t;
        logic seen, stable;
        logic [38:0] held, got;
        foreach (reqs[i]) reqs[i] = rand_req(4'(i + 1));
        idx = 0; seen = 1'b0; stable = 1'b1; held = '0;
        bus.rready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.arvalid = (idx < 6);
            if (idx < 6) begin bus.arid = reqs[idx].id; bus.araddr = reqs[idx].addr; end
            if (bus.rvalid) begin
                got = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
                if (!seen) begin held = got; seen = 1'b1; end
                else if (got !== held) stable = 1'b0;
            end else if (seen) stable = 1'b0;
            if (bus.arvalid && bus.arready) begin
                exp_q.push_back(reqs[idx]);
                idx++;
            end
            tick();
        end
        n_checks++; if (idx != 5) $display("FAIL bp_accepted got=%0d exp=5", idx); else n_pass++;
        n_checks++; if (bus.arready !== 1'b0) $display("FAIL bp_arready_full got=%b exp=0", bus.arready); else n_pass++;
        n_checks++; if (!(seen && stable)) $display("FAIL bp_stall_stable got=seen%b_stable%b exp=seen1_stable1", seen, stable); else n_pass++;
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        t = 0;
        while (exp_q.size() > 0 && t < 60) begin
            if (bus.rvalid) begin
                req_t e;
                e = exp_q.pop_front();
                got = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
                n_checks++; if (got !== model_resp(e)) $display("FAIL bp_resp got=%h exp=%h", got, model_resp(e)); else n_pass++;
            end
            tick(); t++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL bp_drain left=%0d exp=0", exp_q.size()); else n_pass++;
        exp_q.delete();
        n_checks++; if (bus.arready !== 1'b1) $display("FAIL bp_arready_after got=%b exp=1", bus.arready); else n_pass++;
    endtask

    task automatic test_zero_latency();
        req_t q0[$];
        req_t reqs [8];
        int idx, got_n, first_rv;
        logic gap;
        logic [38:0] got;
        foreach (reqs[i]) reqs[i] = rand_req(4'(i));
        idx = 0; got_n = 0; first_rv = -1; gap = 1'b0;
        bus0.rready = 1'b1;
        for (int c = 0; c < 40 && got_n < 8; c++) begin
            bus0.arvalid = (idx < 8);
            if (idx < 8) begin bus0.arid = reqs[idx].id; bus0.araddr = reqs[idx].addr; end
            if (bus0.rvalid) begin
                req_t e;
                if (first_rv < 0) first_rv = c;
                if (q0.size() == 0) begin
                    n_checks++; $display("FAIL zl_spurious got=rid%h exp=none", bus0.rid);
                end else begin
                    e = q0.pop_front();
                    got = {bus0.rid, bus0.rdata, bus0.rresp, bus0.rlast};
                    n_checks++; if (got !== model_resp(e)) $display("FAIL zl_resp got=%h exp=%h", got, model_resp(e)); else n_pass++;
                end
                got_n++;
            end else if (first_rv >= 0) gap = 1'b1;
            if (bus0.arvalid && bus0.arready) begin
                q0.push_back(reqs[idx]);
                idx++;
            end
            tick();
        end
        bus0.arvalid = 1'b0;
        n_checks++; if (got_n != 8) $display("FAIL zl_count got=%0d exp=8", got_n); else n_pass++;
        n_checks++; if (gap !== 1'b0) $display("FAIL zl_continuous got=gap exp=no_gap"); else n_pass++;
        n_checks++; if (first_rv != 2) $display("FAIL zl_first_latency got=%0d exp=2", first_rv); else n_pass++;
        tick();
        n_checks++; if (bus0.rvalid !== 1'b0) $display("FAIL zl_idle_after got=%b exp=0", bus0.rvalid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acc, t;
        logic spurious;
        req_t r;
        acc = 0;
        bus.rready = 1'b0;
        t = 0;
        while (acc < 3 && t < 20) begin
            r = rand_req(4'(acc + 7));
            bus.arvalid = 1'b1; bus.arid = r.id; bus.araddr = r.addr;
            if (bus.arready) acc++;
            tick(); t++;
        end
        bus.arvalid = 1'b0;
        t = 0;
        while (!bus.rvalid && t < 20) begin tick(); t++; end
        n_checks++; if (bus.rvalid !== 1'b1) $display("FAIL rm_pre_rvalid got=%b exp=1", bus.rvalid); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.rvalid, bus.arready, bus.rid, bus.rresp} !== {1'b0, 1'b1, 4'h0, 2'b00})
            $display("FAIL rm_async got=rv%b_ar%b_rid%h_resp%b exp=rv0_ar1_rid0_resp00",
                     bus.rvalid, bus.arready, bus.rid, bus.rresp); else n_pass++;
        tick();
        rst_n = 1'b1;
        bus.rready = 1'b1;
        spurious = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.rvalid) spurious = 1'b1;
        end
        n_checks++; if (spurious !== 1'b0) $display("FAIL rm_stale got=rvalid_seen exp=none"); else n_pass++;
        r = rand_req(4'h9);
        single_timing(r, "rm_after");
    endtask

    task automatic test_wrap();
        req_t reqs [20];
        int sent, got_n;
        logic stall_prev, stall_ok;
        logic [38:0] held, got;
        foreach (reqs[i]) reqs[i] = rand_req(4'(i));
        sent = 0; got_n = 0; stall_prev = 1'b0; stall_ok = 1'b1; held = '0;
        exp_q.delete();
        for (int c = 0; c < 600 && got_n < 20; c++) begin
            bus.arvalid = (sent < 20) && ($urandom_range(0, 3) != 0);
            if (sent < 20) begin bus.arid = reqs[sent].id; bus.araddr = reqs[sent].addr; end
            bus.rready = ($urandom_range(0, 1) == 1);
            got = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
            if (stall_prev && (!bus.rvalid || got !== held)) stall_ok = 1'b0;
            if (bus.rvalid && bus.rready) begin
                req_t e;
                if (exp_q.size() == 0) begin
                    n_checks++; $display("FAIL wrap_spurious got=rid%h exp=none", bus.rid);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (got !== model_resp(e)) $display("FAIL wrap_resp_%0d got=%h exp=%h", got_n, got, model_resp(e)); else n_pass++;
                end
                got_n++;
            end
            if (bus.arvalid && bus.arready) begin
                exp_q.push_back(reqs[sent]);
                sent++;
            end
            stall_prev = bus.rvalid && !bus.rready;
            held = got;
            tick();
        end
        bus.arvalid = 1'b0;
        n_checks++; if (got_n != 20 || exp_q.size() != 0)
            $display("FAIL wrap_count got=%0d_left%0d exp=20_left0", got_n, exp_q.size()); else n_pass++;
        n_checks++; if (stall_ok !== 1'b1) $display("FAIL wrap_stall_stable got=changed exp=stable"); else n_pass++;
    endtask

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus0.arid = '0; bus0.araddr = '0; bus0.arvalid = 1'b0; bus0.rready = 1'b0;
        test_reset();
        test_single();
        test_decode();
        test_backpressure();
        test_zero_latency();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_rd_slv.md
# axi_rd_slv

Single-beat AXI read-slave responder: accepts read-address requests on the AR channel, queues them in a small in-order FIFO, and returns one read-data beat per request on the R channel after a fixed access latency. It sits opposite the team's AR-issuing master as the bus target, serving bench and bring-up traffic with deterministic, address-derived data and decode-error reporting.

## Interface
Parameters:
- ID_W, 4: ARID/RID width
- ADDR_W, 16: ARADDR width
- DATA_W, 32: RDATA width, must equal 2*ADDR_W
- DEPTH, 4: request FIFO entries, power of two, at least 2
- RD_LAT, 2: access latency in cycles, range 0..15
- OK_LIMIT, 16'h00FF: highest address that decodes OKAY

Ports:
- clk  in  1  clock; reset rst_n, asynchronous, active-low; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- axi_slv_arid  in  ID_W  request ID
- axi_slv_araddr  in  ADDR_W  request address
- axi_slv_arvalid  in  1  request valid
- axi_slv_arready  out  1  request ready, high when the FIFO is not full
- axi_slv_rid  out  ID_W  echoed ID
- axi_slv_rdata  out  DATA_W  read data
- axi_slv_rresp  out  2  00 OKAY, 11 DECERR
- axi_slv_rlast  out  1  always equals rvalid (single beat)
- axi_slv_rvalid  out  1  response valid
- axi_slv_rready  in  1  response ready

## Operation
- AR handshake: arvalid & arready at a rising edge pushes {arid, araddr} into the FIFO.
- arready = !full is combinational from the registered count. No push-when-full bypass, even if a pop occurs in the same cycle.
- Response generation happens when an entry is popped:
  - rid = arid.
  - araddr <= OK_LIMIT: rresp = 00, rdata = {~araddr, araddr}.
  - Otherwise: rresp = 11, rdata = 0.
- Responses are returned strictly in acceptance order.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: if the FIFO is non-empty, pop the head and capture the R fields. If RD_LAT = 0, go to RESP; otherwise load cnt = RD_LAT and go to WAIT.
  - WAIT: decrement cnt each cycle. When cnt = 1, go to RESP.
  - RESP: rvalid = 1, and R fields hold stable until rvalid & rready. On the handshake edge:
    - FIFO non-empty: pop the next entry and go to WAIT, or to RESP if RD_LAT = 0. rvalid stays high in the RD_LAT = 0 case.
    - FIFO empty: go to IDLE.
- Push and pop in the same edge leave count unchanged. Count range is 0..DEPTH.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- rvalid never drops without a handshake, and R fields never change while rvalid & !rready.

## Timing
- Reset values: arready 1 (FIFO empty), rvalid 0, rlast 0, rid 0, rdata 0, rresp 00, FSM IDLE, count 0.
- Reset asserted mid-operation flushes the FIFO and any in-flight response immediately. Outputs go to their reset values asynchronously, and no stale response appears after release.
- Latency: an AR handshake at edge E0 into an idle, empty block raises rvalid after edge E0+1+RD_LAT. With the default RD_LAT = 2, rvalid is high in the cycle after edge E3.
- Throughput with rready held high:
  - RD_LAT = 0: one response per cycle.
  - RD_LAT > 0: one response every RD_LAT+1 cycles.
- arready falls in the cycle after the push that makes count = DEPTH. It rises in the cycle after the next pop.

## Test plan
- Single request: arid 3, araddr 0x0001, rready high, RD_LAT 2 -> rvalid exactly 3 cycles after the AR edge, with rid 3, rdata 0xFFFE0001, rresp 00, rlast 1, for one cycle.
- Decode error: araddr 0x0100, arid 0xA -> rresp 11, rdata 0, rid 0xA.
- Backpressure and full: rready held low while 6 requests are offered with arvalid held high -> exactly 5 accepted (4 queued plus 1 popped into RESP), arready low afterwards. After rready is released, all 5 return in order with correct IDs and R fields stable during the stall.
- Zero latency: RD_LAT 0, arvalid and rready held high, IDs 0..7 -> after the first response, rvalid stays continuously high and RIDs 0..7 appear on consecutive cycles.
- Reset mid-operation: 3 requests accepted and rvalid high, then rst_n pulses low for 1 cycle -> rvalid 0 and arready 1 immediately. No response occurs until a new request is accepted, which then follows the single-request timing.
- Wrap-around: 20 sequential requests with random rready -> IDs returned in order across multiple pointer wraps, with no loss or duplication.
